icache_axi_refill: RTL and testbench

- Memory-side refill engine for the instruction cache.
- Accepts a single-line miss request (rd_req/rd_addr) and issues one AXI4 INCR read burst of LINE_WORDS beats.
- Assembles the returned beats into a 256-bit line and returns it to the cache with a one-cycle ret_valid pulse.
- Sits between the icache and the AXI interconnect; owns the AR and R channels only.

---
 rtl/pipeline_types.sv | 20 ++
 rtl/icache_axi_refill_line_buffer.sv | 40 ++++
 rtl/icache_axi_refill.sv | 152 +++++++++++++++
 tb/tb_icache_axi_refill.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_types.sv
// Shared types and AXI constants for the instruction-side memory pipeline.
// Pure declarations: no logic and no latency.
// Holds no flow-control state; the refill FSM encoding lives here so that debug tooling agrees.
package pipeline_types;

    // Refill engine states, in the order a refill visits them
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } refill_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    typedef logic [255:0] bus256_t;
    typedef logic [31:0]  bus32_t;

endpackage

// File: rtl/icache_axi_refill_line_buffer.sv
// Line assembly buffer: LINE_WORDS x 32-bit registers with clear, indexed write and packed read.
// Write lands one cycle after wr_en; the packed line is a direct register view.
// No backpressure: every write strobe is taken, the caller bounds the index.
import pipeline_types::*;

module refill_line_buffer #(
    parameter int LINE_WORDS = 8,
    parameter int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  bus32_t                  wr_data,
    output logic [32*LINE_WORDS-1:0] line
);

    bus32_t words [LINE_WORDS];

    // Word storage: a clear wipes the whole line so short bursts leave zeros behind
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                words[i] <= '0;
            end
        end else if (wr_en) begin
            words[wr_idx] <= wr_data;
        end
    end

    // Pack word i into bits [32i+31:32i]
    always_comb begin
        line = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            line[32*i +: 32] = words[i];
        end
    end

endmodule

// File: rtl/icache_axi_refill.sv
// Icache refill engine: one miss -> one AXI4 INCR read burst -> one 256-bit line pulse (optional ICACHE_REFILL_PERF_EN counters).
// Latency: request sampled in cycle 0, arvalid in cycle 1, line pulse one cycle after the rlast beat (cycle 10 with no stalls).
// Backpressure: arvalid held until arready; rready held high through DATA so the burst always drains, even when flushed.
import pipeline_types::*;

module icache_axi_refill #(
    parameter int         LINE_WORDS = 8,
    parameter logic [3:0] AXI_ID     = 4'd0,
    parameter int         ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              ret_valid,
    output logic [255:0]      ret_data,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
`ifdef ICACHE_REFILL_PERF_EN
    ,
    output logic [31:0]       perf_refill_cnt,
    output logic [31:0]       perf_discard_cnt,
    output logic [31:0]       perf_busy_cycles
`endif
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int CNT_W = $clog2(LINE_WORDS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LINE_WORDS);

    refill_state_t     state;
    logic [ADDR_W-6:0] line_addr;
    logic [CNT_W-1:0]  beat_cnt;
    logic              discard;
    logic              buf_clear;
    logic              buf_wr;
    bus256_t           line;

    // Line offset bits, rid and rresp carry nothing this engine acts on
    logic unused_inputs;
    assign unused_inputs = ^{rd_addr[4:0], rid, rresp};

    assign buf_clear = (state == ST_IDLE) && rd_req && !flush;
    // Beats past the end of the line are accepted but not stored
    assign buf_wr    = (state == ST_DATA) && rvalid && (beat_cnt < CNT_FULL);

    // Refill sequencing: accept miss, hold AR until taken, drain R until rlast, one response cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            line_addr <= '0;
            beat_cnt  <= '0;
            discard   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_req && !flush) begin
                        line_addr <= rd_addr[ADDR_W-1:5];
                        beat_cnt  <= '0;
                        state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (flush) begin
                        discard <= 1'b1;
                    end
                    if (arready) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (flush) begin
                        discard <= 1'b1;
                    end
                    if (rvalid) begin
                        if (beat_cnt < CNT_FULL) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                        if (rlast) begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    discard <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    refill_line_buffer #(
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W)
    ) u_line_buffer (
        .clk     (clk),
        .reset   (reset),
        .clear   (buf_clear),
        .wr_en   (buf_wr),
        .wr_idx  (beat_cnt[IDX_W-1:0]),
        .wr_data (rdata),
        .line    (line)
    );

    // AXI and return outputs are pure state decodes so they drop the cycle reset lands
    always_comb begin
        arvalid   = (state == ST_ADDR);
        rready    = (state == ST_DATA);
        ret_valid = (state == ST_RESP) && !discard && !flush;
        ret_data  = line;
        araddr    = {line_addr, 5'b0};
        arid      = AXI_ID;
        arlen     = 8'(LINE_WORDS - 1);
        arsize    = AXI_SIZE_4B;
        arburst   = AXI_BURST_INCR;
    end

`ifdef ICACHE_REFILL_PERF_EN
    // Observation-only counters, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_refill_cnt  <= '0;
            perf_discard_cnt <= '0;
            perf_busy_cycles <= '0;
        end else begin
            if (ret_valid) begin
                perf_refill_cnt <= perf_refill_cnt + 32'd1;
            end
            if ((state == ST_RESP) && (discard || flush)) begin
                perf_discard_cnt <= perf_discard_cnt + 32'd1;
            end
            if (state != ST_IDLE) begin
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_axi_refill.sv
// Bench for icache_axi_refill: the bench plays icache and AXI slave, a monitor scores AR and line returns.
// Expected lines come from a word-array model of the burst (first 8 beats kept, missing words zero).
// The slave stalls arready and gaps rvalid at random.
module tb_icache_axi_refill;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         rd_req;
    logic [31:0]  rd_addr;
    logic         ret_valid;
    logic [255:0] ret_data;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
`ifdef ICACHE_REFILL_PERF_EN
    logic [31:0]  perf_refill_cnt;
    logic [31:0]  perf_discard_cnt;
    logic [31:0]  perf_busy_cycles;
`endif

    icache_axi_refill dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .ret_valid (ret_valid),
        .ret_data  (ret_data),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready)
`ifdef ICACHE_REFILL_PERF_EN
        ,
        .perf_refill_cnt  (perf_refill_cnt),
        .perf_discard_cnt (perf_discard_cnt),
        .perf_busy_cycles (perf_busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [255:0] data;
        int           lat;
        int           req_cyc;
    } ret_exp_t;

    logic [31:0] exp_ar[$];
    ret_exp_t    exp_ret[$];
    int          n_delivered = 0;
    int          n_discarded = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: event missing or unexpected", nm);
    endtask

    // Reference line: beat i fills word i for the first 8 beats, unfilled words read zero
    function automatic logic [255:0] model_line(input logic [31:0] d[10], input int n);
        logic [255:0] l;
        l = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < n) l[32*i +: 32] = d[i];
        end
        return l;
    endfunction

    // Monitor: AR handshakes and line returns against the scoreboard queues
    logic [31:0] ar_hold;
    bit          ar_wait = 0;
    always @(negedge clk) begin
        if (reset) begin
            ar_wait = 0;
        end else begin
            if (arvalid) begin
                if (ar_wait) chk("araddr_stable", araddr, ar_hold);
                ar_hold = araddr;
                ar_wait = 1;
                if (arready) begin
                    ar_wait = 0;
                    if (exp_ar.size() == 0) begin
                        fail_now("unexpected_ar");
                    end else begin
                        logic [31:0] ea;
                        ea = exp_ar.pop_front();
                        chk("araddr", araddr, ea);
                        chk("arlen", arlen, 8'd7);
                        chk("arsize", arsize, 3'b010);
                        chk("arburst", arburst, 2'b01);
                        chk("arid", arid, 4'd0);
                    end
                end
            end
            if (ret_valid) begin
                if (exp_ret.size() == 0) begin
                    fail_now("unexpected_ret_valid");
                end else begin
                    ret_exp_t e;
                    e = exp_ret.pop_front();
                    chk("ret_data", ret_data, e.data);
                    if (e.lat >= 0) chk("ret_latency", 256'(cyc - e.req_cyc), 256'(e.lat));
                end
            end
        end
    end

    // One refill as icache + AXI slave; flush_beat<0 means no flush in DATA
    task automatic do_refill(input logic [31:0] addr, input int n, input int ar_dly,
                             input int gap_pct, input int flush_beat, input bit flush_addr,
                             input bit seq_data, input bit chk_lat);
        logic [31:0] d[10];
        bit          flushed;
        int          t;
        ret_exp_t    e;
        for (int i = 0; i < 10; i++) d[i] = seq_data ? 32'h100 + 32'(i) : $urandom;
        flushed = (flush_beat >= 0) || (flush_addr && ar_dly > 0);
        exp_ar.push_back(addr & ~32'h1F);
        if (!flushed) begin
            e.data    = model_line(d, n);
            e.lat     = chk_lat ? 10 : -1;
            e.req_cyc = cyc;
            exp_ret.push_back(e);
            n_delivered++;
        end else begin
            n_discarded++;
        end
        rd_addr = addr;
        rd_req  = 1'b1;
        arready = (ar_dly == 0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!arvalid && t < 50);
        if (!arvalid) begin
            fail_now("arvalid_timeout");
            rd_req = 1'b0;
            arready = 1'b0;
            return;
        end
        if (ar_dly > 0) begin
            for (int k = 0; k < ar_dly; k++) begin
                if (flush_addr && k == 0) flush = 1'b1;
                @(posedge clk);
                #1;
                flush = 1'b0;
            end
            arready = 1'b1;
        end
        @(posedge clk);
        #1;
        arready = 1'b0;
        for (int b = 0; b < n; b++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                rvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            rvalid = 1'b1;
            rdata  = d[b];
            rlast  = (b == n - 1);
            flush  = (b == flush_beat);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!rready && t < 50);
            if (!rready) begin
                fail_now("rready_timeout");
                rvalid = 1'b0;
                rlast = 1'b0;
                flush = 1'b0;
                rd_req = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            rvalid = 1'b0;
            rlast  = 1'b0;
            flush  = 1'b0;
        end
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        flush   = 1'b0;
        rd_req  = 1'b0;
        rd_addr = '0;
        arready = 1'b0;
        rid     = 4'h5;
        rdata   = '0;
        rresp   = 2'b10;
        rlast   = 1'b0;
        rvalid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_arvalid", arvalid, 1'b0);
        chk("reset_rready", rready, 1'b0);
        chk("reset_ret_valid", ret_valid, 1'b0);
        chk("reset_ret_data", ret_data, 256'd0);
        @(posedge clk);
        #1;

        // Directed: no stalls, sequential data, latency 10
        do_refill(32'h1C00_0044, 8, 0, 0, -1, 0, 1, 1);
        // Stalled AR and toggling rvalid
        do_refill(32'h2000_1234, 8, 5, 100, -1, 0, 0, 0);
        // Flush on the third DATA beat, then a clean refill
        do_refill(32'h3000_0000, 8, 0, 0, 2, 0, 0, 0);
        do_refill(32'h1C00_1000, 8, 0, 0, -1, 0, 0, 0);
        // Early rlast and overlong burst
        do_refill(32'h4000_00E0, 4, 1, 0, -1, 0, 0, 0);
        do_refill(32'h5000_0020, 10, 0, 30, -1, 0, 0, 0);

        // Request coinciding with flush in IDLE is ignored
        rd_addr = 32'h6000_0000;
        rd_req  = 1'b1;
        flush   = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        flush  = 1'b0;
        @(negedge clk);
        chk("idle_flush_no_ar", arvalid, 1'b0);
        @(posedge clk);
        #1;

        // Reset in DATA after three beats
        exp_ar.push_back(32'h7000_0040);
        rd_addr = 32'h7000_0040;
        rd_req  = 1'b1;
        arready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        arready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            rvalid = 1'b1;
            rdata  = 32'hDEAD_0000 + 32'(b);
            @(posedge clk);
            #1;
        end
        reset  = 1'b1;
        rvalid = 1'b0;
        rd_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_arvalid", arvalid, 1'b0);
        chk("rst_mid_rready", rready, 1'b0);
        chk("rst_mid_ret_valid", ret_valid, 1'b0);
        chk("rst_mid_ret_data", ret_data, 256'd0);
        n_delivered = 0;
        n_discarded = 0;
        @(posedge clk);
        #1;
        do_refill(32'h7000_0080, 8, 0, 0, -1, 0, 0, 0);

        // Randomized refills
        for (int r = 0; r < 24; r++) begin
            int n, fb;
            n  = ($urandom_range(0, 9) < 6) ? 8 : int'($urandom_range(1, 10));
            fb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            do_refill($urandom, n, $urandom_range(0, 4), $urandom_range(0, 1) * 40,
                      fb, ($urandom_range(0, 7) == 0), 0, 0);
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("pending_ret_empty", 256'(exp_ret.size()), 256'd0);
        chk("pending_ar_empty", 256'(exp_ar.size()), 256'd0);
`ifdef ICACHE_REFILL_PERF_EN
        chk("perf_refill_cnt", perf_refill_cnt, 32'(n_delivered));
        chk("perf_discard_cnt", perf_discard_cnt, 32'(n_discarded));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
